cacheline_mem_arbiter: RTL and testbench

Registered, starvation-free arbiter that shares the single cacheline-wide physical memory port between the instruction cache (port A) and the data cache (port B). It latches the winning request, holds it stable on the memory side until `resp`, and then returns the response and line data to the winner as a registered one-cycle pulse. The data port has priority, but a bounded counter guarantees that instruction fetches are not starved.

---
 rtl/cacheline_mem_arbiter_if.sv | 23 ++
 rtl/cacheline_mem_arbiter.sv | 116 +++++++++++
 tb/tb_cacheline_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_mem_arbiter_if.sv
// Cacheline-wide request/response bus shared by both cache ports and the memory side.
// The master drives strobes, address and write data; the slave returns resp and read data.
interface cacheline_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) ();
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [LINE_WIDTH-1:0] wdata;
  logic                  resp;
  logic [LINE_WIDTH-1:0] rdata;

  modport master (
    output read, write, address, wdata,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata,
    output resp, rdata
  );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates one cacheline memory port between the I-cache (port_a) and the D-cache (port_b).
// The D-cache has priority; a saturating counter hands the port to the I-cache after STARVE_LIMIT losses.
module cacheline_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cacheline_mem_arbiter_if.slave  port_a,
  cacheline_mem_arbiter_if.slave  port_b,
  cacheline_mem_arbiter_if.master mem,
  output logic                    busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SERVE_A = 3'd1;
  localparam logic [2:0] SERVE_B = 3'd2;
  localparam logic [2:0] DONE_A  = 3'd3;
  localparam logic [2:0] DONE_B  = 3'd4;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [2:0]            state_reg, state_next;
  logic [3:0]            starve_cnt_reg, starve_cnt_next;
  logic                  op_write_reg, op_write_next;
  logic [ADDR_WIDTH-1:0] address_reg, address_next;
  logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  req_a, req_b;
  logic                  serving;
  logic [LINE_WIDTH-1:0] rdata_vec [2];

  assign req_a = port_a.read | port_a.write;
  assign req_b = port_b.read | port_b.write;

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    op_write_next   = op_write_reg;
    address_next    = address_reg;
    wdata_next      = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req_a && (!req_b || starve_cnt_reg == LIMIT)) begin
          state_next      = SERVE_A;
          op_write_next   = port_a.write;
          address_next    = port_a.address;
          wdata_next      = port_a.wdata;
          starve_cnt_next = '0;
        end else if (req_b) begin
          state_next    = SERVE_B;
          op_write_next = port_b.write;
          address_next  = port_b.address;
          wdata_next    = port_b.wdata;
          // Only losses while A is actually waiting count towards starvation.
          if (!req_a)
            starve_cnt_next = '0;
          else if (starve_cnt_reg >= LIMIT)
            starve_cnt_next = LIMIT;
          else
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
      end
      SERVE_A: if (mem.resp) state_next = DONE_A;
      SERVE_B: if (mem.resp) state_next = DONE_B;
      DONE_A:  state_next = IDLE;
      DONE_B:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      op_write_reg   <= 1'b0;
      address_reg    <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      op_write_reg   <= op_write_next;
      address_reg    <= address_next;
      wdata_reg      <= wdata_next;
    end
  end

  // Per-port read-line holding registers; only a read completion on that port updates them.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic [2:0] SERVE_ST = (gi == 0) ? SERVE_A : SERVE_B;
    logic [LINE_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (rst)
        rdata_reg <= '0;
      else if (state_reg == SERVE_ST && mem.resp && !op_write_reg)
        rdata_reg <= mem.rdata;
    end

    assign rdata_vec[gi] = rdata_reg;
  end

  assign serving     = (state_reg == SERVE_A) || (state_reg == SERVE_B);
  assign mem.read    = serving & ~op_write_reg;
  assign mem.write   = serving & op_write_reg;
  assign mem.address = address_reg;
  assign mem.wdata   = wdata_reg;

  assign port_a.resp  = (state_reg == DONE_A);
  assign port_b.resp  = (state_reg == DONE_B);
  assign port_a.rdata = rdata_vec[0];
  assign port_b.rdata = rdata_vec[1];

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Randomised scoreboard bench for cacheline_mem_arbiter: two cache requesters, a random-latency
// memory, and a transaction-level model predicting grant order, memory-side values and responses.
module tb_cacheline_mem_arbiter;
  localparam int AW    = 32;
  localparam int LW    = 256;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  cacheline_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) a_if ();
  cacheline_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) b_if ();
  cacheline_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) m_if ();

  cacheline_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .port_a (a_if.slave),
    .port_b (b_if.slave),
    .mem    (m_if.master),
    .busy   (busy)
  );

  logic          drv_read  [2];
  logic          drv_write [2];
  logic [AW-1:0] drv_addr  [2];
  logic [LW-1:0] drv_wdata [2];
  logic          tb_resp;
  logic [LW-1:0] tb_rdata;

  assign a_if.read    = drv_read[0];
  assign a_if.write   = drv_write[0];
  assign a_if.address = drv_addr[0];
  assign a_if.wdata   = drv_wdata[0];
  assign b_if.read    = drv_read[1];
  assign b_if.write   = drv_write[1];
  assign b_if.address = drv_addr[1];
  assign b_if.wdata   = drv_wdata[1];
  assign m_if.resp    = tb_resp;
  assign m_if.rdata   = tb_rdata;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string got, input string want);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %s expected %s", name, got, want);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic port_resp(input int p);
    return (p == 0) ? a_if.resp : b_if.resp;
  endfunction

  // Port inputs as seen at each rising edge, i.e. what a grant decision would latch.
  logic          s_req   [2];
  logic          s_wr    [2];
  logic [AW-1:0] s_addr  [2];
  logic [LW-1:0] s_wdata [2];

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      s_req[p]   <= drv_read[p] | drv_write[p];
      s_wr[p]    <= drv_write[p];
      s_addr[p]  <= drv_addr[p];
      s_wdata[p] <= drv_wdata[p];
    end
  end

  typedef struct {
    int            port;
    bit            wr;
    logic [LW-1:0] rdata;
  } resp_t;

  resp_t         exp_q[$];
  int            starve = 0;
  logic [LW-1:0] exp_rdata [2];
  bit            granted   [2];
  bit            mem_en = 1'b0;

  // Memory model: on each new transaction predict the winner, check the held request, then respond.
  initial begin : mem_model
    tb_resp  = 1'b0;
    tb_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && (m_if.read || m_if.write)) begin
        int            win;
        int            lat;
        bit            wr;
        logic [AW-1:0] ea;
        logic [LW-1:0] ew;
        logic [LW-1:0] rd;
        if (s_req[0] && s_req[1]) win = (starve == LIMIT) ? 0 : 1;
        else if (s_req[0])        win = 0;
        else if (s_req[1])        win = 1;
        else begin
          fail("grant_source", "grant with no request", "no grant");
          win = 0;
        end
        if (win == 1) starve = s_req[0] ? ((starve >= LIMIT) ? LIMIT : starve + 1) : 0;
        else          starve = 0;
        wr = s_wr[win];
        ea = s_addr[win];
        ew = s_wdata[win];
        granted[win] = 1'b1;
        lat = $urandom_range(1, 4);
        for (int c = 1; c <= lat; c++) begin
          if (c > 1) @(negedge clk);
          check("mem_write", LW'(m_if.write), LW'(wr));
          check("mem_read", LW'(m_if.read), LW'(!wr));
          check("mem_address", LW'(m_if.address), LW'(ea));
          check("mem_wdata", m_if.wdata, ew);
        end
        rd       = rand_line();
        tb_resp  = 1'b1;
        tb_rdata = rd;
        exp_q.push_back('{win, wr, rd});
        @(negedge clk);
        tb_resp  = 1'b0;
        tb_rdata = rand_line();
      end
    end
  end

  // Response monitor: every resp_x pulse is matched against the next predicted completion.
  initial begin : resp_mon
    resp_t e;
    forever begin
      @(negedge clk);
      if (a_if.resp && b_if.resp) fail("resp_exclusive", "resp_a=resp_b=1", "at most one");
      for (int p = 0; p < 2; p++) begin
        if (port_resp(p)) begin
          check("done_strobes", LW'({m_if.read, m_if.write}), '0);
          if (exp_q.size() == 0) begin
            fail("resp_expected", $sformatf("resp on port %0d", p), "no response");
          end else begin
            e = exp_q.pop_front();
            check("resp_port", LW'(p), LW'(e.port));
            if (!e.wr) exp_rdata[e.port] = e.rdata;
          end
          check("rdata_a", a_if.rdata, exp_rdata[0]);
          check("rdata_b", b_if.rdata, exp_rdata[1]);
        end
      end
    end
  end

  // One requester: issue, hold until resp_x, then drop; inputs may wander once granted.
  task automatic requester(input int p, input int n, input int maxgap);
    int op;
    bit done;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      @(negedge clk);
      op           = $urandom_range(0, 3);
      drv_addr[p]  = $urandom & ~32'h3f;
      drv_wdata[p] = rand_line();
      granted[p]   = 1'b0;
      drv_write[p] = (op == 1) || (op == 2);
      drv_read[p]  = (op != 1);
      done = 1'b0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
        @(negedge clk);
        if (port_resp(p)) done = 1'b1;
        else if (granted[p] && $urandom_range(0, 1) == 1) begin
          drv_addr[p]  = $urandom;
          drv_wdata[p] = rand_line();
        end
      end
      if (!done) fail($sformatf("resp_timeout_port%0d", p), "no resp in 300 cycles", "resp");
      drv_read[p]  = 1'b0;
      drv_write[p] = 1'b0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [LW-1:0] junk;
    bit            seen;
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      drv_read[p]  = 1'b0;
      drv_write[p] = 1'b0;
      drv_addr[p]  = '0;
      drv_wdata[p] = '0;
      exp_rdata[p] = '0;
      granted[p]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset_read", LW'(m_if.read), '0);
    check("reset_write", LW'(m_if.write), '0);
    check("reset_busy", LW'(busy), '0);
    check("reset_resp_a", LW'(a_if.resp), '0);
    check("reset_resp_b", LW'(b_if.resp), '0);
    check("reset_address", LW'(m_if.address), '0);
    check("reset_wdata", m_if.wdata, '0);
    check("reset_rdata_a", a_if.rdata, '0);
    check("reset_rdata_b", b_if.rdata, '0);
    rst = 1'b0;

    // Spurious resp in IDLE must be ignored.
    @(negedge clk);
    tb_resp  = 1'b1;
    tb_rdata = rand_line();
    @(negedge clk);
    tb_resp = 1'b0;
    check("spurious_busy", LW'(busy), '0);
    check("spurious_resp_a", LW'(a_if.resp), '0);
    check("spurious_resp_b", LW'(b_if.resp), '0);
    @(negedge clk);
    check("spurious_rdata_a", a_if.rdata, '0);
    check("spurious_rdata_b", b_if.rdata, '0);
    check("spurious_idle", LW'(busy), '0);

    // Reset during SERVE_A abandons the transaction and ignores a late resp.
    drv_addr[0] = 32'h40;
    drv_read[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = m_if.read;
    end
    if (!seen) fail("rst_test_grant", "no read strobe", "read=1");
    check("rst_test_address", LW'(m_if.address), LW'(32'h40));
    drv_read[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_read", LW'(m_if.read), '0);
    check("rst_mid_busy", LW'(busy), '0);
    @(negedge clk);
    junk     = rand_line();
    tb_resp  = 1'b1;
    tb_rdata = junk;
    @(negedge clk);
    tb_resp = 1'b0;
    check("late_resp_a", LW'(a_if.resp), '0);
    @(negedge clk);
    check("late_resp_a_done", LW'(a_if.resp), '0);
    check("late_rdata_a", a_if.rdata, '0);
    check("late_busy", LW'(busy), '0);

    // Starvation: both sides request back to back, then fully random traffic.
    mem_en = 1'b1;
    fork
      requester(0, 4, 0);
      requester(1, 24, 0);
    join
    fork
      requester(0, 40, 4);
      requester(1, 40, 4);
    join

    for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    check("drained_queue", LW'(exp_q.size()), '0);
    check("final_busy", LW'(busy), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
